seg7_capture: RTL and testbench
===============================

Name: seg7_capture

Overview:
- Receiving end of the 7-segment output interface driven by the RISC-V block.
- Samples the 7-bit segment bus, waits for each pattern to be stable, and decodes it back to a hex nibble (or flags it as invalid).
- Queues decoded digits in a small first-word-fall-through (FWFT) FIFO, so a bench or on-chip checker can read back the digit stream the core displayed.

Parameters:
- STABLE_CYCLES, 4: consecutive identical samples required before a pattern is accepted; legal range 1..255.
- DEPTH, 8: FIFO entries; must be a power of 2, at least 2.
- HOLD_CYCLES, 64: re-capture interval for a held pattern; used only with SEG7_HOLD_REPEAT_EN.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-low.
- segments  input  7  segment bus; bit0=a … bit6=g; active-high.
- rd_en  input  1  pop the head entry; ignored when rd_valid=0.
- rd_data  output  5  head entry {err, nibble[3:0]}; valid while rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- full  output  1  FIFO holds DEPTH entries.
- count  output  $clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky flag: a capture was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0 at a clk edge):
  - FIFO emptied; rd_valid=0, full=0, count=0, rd_data=0, overflow=0.
  - Stability counter cleared.
  - Last-captured pattern set to 7'h00 (blank).
  - Reset mid-stream discards any partially counted pattern. A pattern already on the bus when rst rises must again be seen STABLE_CYCLES times.
- Stability detection:
  - A pattern P is "accepted" on the STABLE_CYCLES-th consecutive rising edge at which segments==P.
  - Any change in segments restarts the count at 1 with the new value.
  - The counter saturates; it does not wrap.
- Capture rule:
  - On acceptance, if P differs from last-captured, update last-captured := P.
  - If P is also non-blank, push an entry in the same edge.
  - Blank (7'h00) is never pushed, but it updates last-captured. A blank therefore re-arms capture of a repeated digit.
  - P equal to last-captured: no push.
- Decode table (hex pattern → nibble, err=0):
  - 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7
  - 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F
  - Any other non-blank pattern → err=1, nibble=0.
- Latency: rd_valid/rd_data reflect the pushed entry immediately after the accepting edge (FWFT).
- FIFO:
  - A pop happens on an edge with rd_en=1 and rd_valid=1; the next entry appears after that edge.
  - Push and pop in the same edge: count unchanged, both succeed, including when full.
  - Push while full and no pop: entry dropped, overflow:=1. overflow is cleared only by reset.
  - rd_en while empty: no effect; count stays 0 (no underflow).
  - Pointers wrap modulo DEPTH.

Optional Feature:
- Macro: SEG7_HOLD_REPEAT_EN.
- Defined:
  - After a non-blank capture, if the bus stays equal to that pattern, an additional identical entry is pushed every HOLD_CYCLES edges, counted from the capturing edge.
  - Any bus change cancels the hold timer.
  - Repeat pushes obey the same full/overflow rules.
- Undefined: no repeat logic is instantiated; a held pattern produces exactly one entry.

Test Plan:
- Reset sequence: hold rst=0 for 3 cycles with segments=7'h3F → rd_valid=0, count=0, overflow=0. Release rst; keep 7'h3F for 4 edges → one entry, rd_data=5'h00.
- Digit stream: drive 06, 5B, 4F, each for 4 cycles → count=3. Pop 3 times → rd_data 5'h01, 5'h02, 5'h03; then rd_valid=0.
- Glitch rejection: drive 7'h06 for 3 cycles, then 7'h7F for 4 cycles → single entry 5'h08, no 5'h01.
- Repeat and blank:
  - 6D (4 cycles), 00 (4 cycles), 6D (4 cycles) → two entries of 5'h05.
  - 6D held 20 cycles with the macro undefined → one entry.
  - Invalid pattern 7'h01 → entry 5'h10.
- Full/overflow: push 9 distinct alternating digits without reading (DEPTH=8) → full=1, count=8, overflow=1, head=first digit. Next, push with rd_en=1 simultaneously → count stays 8, overflow remains 1.
- With SEG7_HOLD_REPEAT_EN, HOLD_CYCLES=16: hold 7'h77 for 4+40 cycles → 3 entries of 5'h0A. Change to 7'h00 → no further entries.

Source files
------------

// File: rtl/seg7_capture.sv
// Recovers the hex digit stream from a 7-segment bus: debounce, decode, FWFT FIFO.
// Optional SEG7_HOLD_REPEAT_EN: re-push a held pattern every HOLD_CYCLES edges.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned DEPTH         = 8,
  parameter int unsigned HOLD_CYCLES   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               segments,
  input  logic                     rd_en,
  output logic [4:0]               rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = 8;

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
    $error("seg7_capture: STABLE_CYCLES out of range");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("seg7_capture: DEPTH must be a power of 2, at least 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("seg7_capture: HOLD_CYCLES must be at least 1");
  end

  // Segment pattern to {err, nibble}; anything unrecognised is an error entry.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h3F: decode = 5'h00;
      7'h06: decode = 5'h01;
      7'h5B: decode = 5'h02;
      7'h4F: decode = 5'h03;
      7'h66: decode = 5'h04;
      7'h6D: decode = 5'h05;
      7'h7D: decode = 5'h06;
      7'h07: decode = 5'h07;
      7'h7F: decode = 5'h08;
      7'h6F: decode = 5'h09;
      7'h77: decode = 5'h0A;
      7'h7C: decode = 5'h0B;
      7'h39: decode = 5'h0C;
      7'h5E: decode = 5'h0D;
      7'h79: decode = 5'h0E;
      7'h71: decode = 5'h0F;
      default: decode = 5'h10;
    endcase
  endfunction

  logic [SW-1:0] stab_cnt, stab_cnt_n;
  logic [6:0]    seg_q, seg_n;
  logic [6:0]    last_q, last_n;
  logic          restart, accept, cap_new, cap_push, push;

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [CW-1:0] count_n;
  logic [4:0]    entry, head_n;
  logic          pop, wr, ovf_n, full_n, valid_n;

  // Stability counter: restarts on any bus change, saturates instead of wrapping.
  always_comb begin
    restart    = (stab_cnt == '0) || (segments != seg_q);
    seg_n      = segments;
    stab_cnt_n = stab_cnt;
    if (restart) begin
      stab_cnt_n = SW'(1);
    end else if (stab_cnt != {SW{1'b1}}) begin
      stab_cnt_n = stab_cnt + SW'(1);
    end
    accept   = (stab_cnt_n == SW'(STABLE_CYCLES)) && (restart || (stab_cnt_n != stab_cnt));
    cap_new  = accept && (segments != last_q);
    last_n   = cap_new ? segments : last_q;
    cap_push = cap_new && (segments != 7'h00);
  end

`ifdef SEG7_HOLD_REPEAT_EN
  localparam int unsigned HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);

  logic [HW-1:0] hold_cnt, hold_cnt_n;
  logic          hold_act, hold_act_n, hold_push;

  // Hold timer runs from the capturing edge while the bus keeps the captured pattern.
  always_comb begin
    hold_cnt_n = hold_cnt;
    hold_act_n = hold_act;
    hold_push  = 1'b0;
    if (cap_push) begin
      hold_act_n = 1'b1;
      hold_cnt_n = '0;
    end else if (hold_act && (segments == last_q)) begin
      if (hold_cnt == HW'(HOLD_CYCLES - 1)) begin
        hold_push  = 1'b1;
        hold_cnt_n = '0;
      end else begin
        hold_cnt_n = hold_cnt + HW'(1);
      end
    end else begin
      hold_act_n = 1'b0;
    end
    push = cap_push || hold_push;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_cnt <= '0;
      hold_act <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_n;
      hold_act <= hold_act_n;
    end
  end
`else
  always_comb begin
    push = cap_push;
  end
`endif

  // FIFO next state; the head register keeps rd_data registered yet first-word-fall-through.
  always_comb begin
    entry    = decode(last_n);
    pop      = rd_en && rd_valid;
    wr       = push && (!full || pop);
    ovf_n    = overflow || (push && full && !pop);
    wr_ptr_n = wr ? wr_ptr + AW'(1) : wr_ptr;
    rd_ptr_n = pop ? rd_ptr + AW'(1) : rd_ptr;
    count_n  = count;
    if (wr && !pop) begin
      count_n = count + CW'(1);
    end else if (pop && !wr) begin
      count_n = count - CW'(1);
    end
    if (count_n == '0) begin
      head_n = '0;
    end else if (wr && ((count == '0) || ((count == CW'(1)) && pop))) begin
      head_n = entry;
    end else begin
      head_n = mem[rd_ptr_n];
    end
    full_n  = (count_n == CW'(DEPTH));
    valid_n = (count_n != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stab_cnt <= '0;
      seg_q    <= 7'h00;
      last_q   <= 7'h00;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      stab_cnt <= stab_cnt_n;
      seg_q    <= seg_n;
      last_q   <= last_n;
      wr_ptr   <= wr_ptr_n;
      rd_ptr   <= rd_ptr_n;
      count    <= count_n;
      rd_data  <= head_n;
      rd_valid <= valid_n;
      full     <= full_n;
      overflow <= ovf_n;
    end
  end

  // Storage needs no reset: entries are only read when occupancy says they are valid.
  always_ff @(posedge clk) begin
    if (rst && wr) begin
      mem[wr_ptr] <= entry;
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Scoreboard bench for seg7_capture: a digit model queues expected entries, pops compare.
// Exercises the SEG7_HOLD_REPEAT_EN repeat path when that macro is defined.
module tb_seg7_capture;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned S     = 4;
  localparam int unsigned HOLD  = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] segments = 7'h00;
  logic       rd_en = 1'b0;
  logic [4:0] rd_data;
  logic       rd_valid;
  logic       full;
  logic [3:0] count;
  logic       overflow;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];
  logic [6:0] model_last = 7'h00;
  logic       model_ovf  = 1'b0;
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  seg7_capture #(.STABLE_CYCLES(S), .DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .segments(segments), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] ref_decode(input logic [6:0] p);
    ref_decode = 5'h10;
    for (int i = 0; i < 16; i++) if (tbl[i] == p) ref_decode = {1'b0, 4'(i)};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive_raw(input logic [6:0] p, input int n);
    segments = p;
    rd_en = 1'b0;
    repeat (n) step();
  endtask

  // Drive a pattern that differs from the previous bus value and update the model.
  task automatic drive_pat(input logic [6:0] p, input int n);
    int reps;
    drive_raw(p, n);
    if (n >= int'(S) && p != model_last) begin
      model_last = p;
      if (p != 7'h00) begin
        reps = 1;
`ifdef SEG7_HOLD_REPEAT_EN
        reps += (n - int'(S)) / int'(HOLD);
`endif
        for (int r = 0; r < reps; r++) begin
          if (exp_q.size() < int'(DEPTH)) exp_q.push_back(ref_decode(p));
          else model_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] e;
    rst = 1'b0;
    segments = 7'h3F;
    repeat (3) step();
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b want 0", rd_valid); end
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b want 0", overflow); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full: got %0b want 0", full); end
    total++; if (rd_data !== 5'h00) begin bad++; $display("FAIL reset_data: got %h want 00", rd_data); end
    rst = 1'b1;
    exp_q.delete();
    model_last = 7'h00;
    model_ovf = 1'b0;
    drive_pat(7'h3F, 4);
    total++; if (count !== 4'(exp_q.size())) begin bad++; $display("FAIL reset_first_count: got %0d want %0d", count, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== e) begin bad++; $display("FAIL reset_pop: valid=%0b data=%h want %h", rd_valid, rd_data, e); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    // Partially counted pattern must restart after a mid-stream reset.
    drive_raw(7'h06, 2);
    rst = 1'b0; step(); rst = 1'b1;
    drive_raw(7'h06, 3);
    total++; if (count !== 4'd0) begin bad++; $display("FAIL reset_midstream: count=%0d want 0", count); end
    drive_raw(7'h06, 1);
    model_last = 7'h06;
    exp_q.push_back(ref_decode(7'h06));
    total++; if (count !== 4'd1) begin bad++; $display("FAIL reset_recount: count=%0d want 1", count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== e) begin bad++; $display("FAIL reset_pop2: valid=%0b data=%h want %h", rd_valid, rd_data, e); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
  endtask

  task automatic test_digit_stream();
    logic [4:0] e;
    drive_pat(7'h00, 4);
    drive_pat(7'h06, 4);
    drive_pat(7'h5B, 4);
    drive_pat(7'h4F, 4);
    total++; if (count !== 4'd3) begin bad++; $display("FAIL stream_count: got %0d want 3", count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== e) begin bad++; $display("FAIL stream_pop: valid=%0b data=%h want %h", rd_valid, rd_data, e); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL stream_empty: valid=%0b want 0", rd_valid); end
    rd_en = 1'b1; step(); rd_en = 1'b0;
    total++; if (count !== 4'd0 || rd_valid !== 1'b0) begin bad++; $display("FAIL underflow: count=%0d valid=%0b want 0/0", count, rd_valid); end
  endtask

  task automatic test_glitch();
    logic [4:0] e;
    drive_pat(7'h00, 4);
    drive_pat(7'h06, 3);
    drive_pat(7'h7F, 4);
    total++; if (count !== 4'(exp_q.size())) begin bad++; $display("FAIL glitch_count: got %0d want %0d", count, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== e) begin bad++; $display("FAIL glitch_pop: valid=%0b data=%h want %h", rd_valid, rd_data, e); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
  endtask

  task automatic test_repeat_blank();
    logic [4:0] e;
    drive_pat(7'h00, 4);
    drive_pat(7'h6D, 4);
    drive_pat(7'h00, 4);
    drive_pat(7'h6D, 4);
    total++; if (count !== 4'd2) begin bad++; $display("FAIL blank_rearm_count: got %0d want 2", count); end
    drive_pat(7'h00, 4);
    drive_pat(7'h6D, 20);
    total++; if (count !== 4'(exp_q.size())) begin bad++; $display("FAIL held_count: got %0d want %0d", count, exp_q.size()); end
    drive_pat(7'h00, 4);
    drive_pat(7'h01, 4);
    total++; if (count !== 4'(exp_q.size())) begin bad++; $display("FAIL invalid_count: got %0d want %0d", count, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== e) begin bad++; $display("FAIL repeat_pop: valid=%0b data=%h want %h", rd_valid, rd_data, e); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
  endtask

  task automatic test_full_overflow();
    logic [4:0] e;
    drive_pat(7'h00, 4);
    for (int i = 0; i < 9; i++) drive_pat(tbl[i], 4);
    total++; if (full !== 1'b1 || count !== 4'(exp_q.size())) begin bad++; $display("FAIL full_state: full=%0b count=%0d want 1/%0d", full, count, exp_q.size()); end
    total++; if (overflow !== model_ovf) begin bad++; $display("FAIL overflow_set: got %0b want %0b", overflow, model_ovf); end
    total++; if (rd_data !== exp_q[0]) begin bad++; $display("FAIL full_head: got %h want %h", rd_data, exp_q[0]); end
    // Push and pop on the same edge while full.
    drive_raw(tbl[9], 3);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(ref_decode(tbl[9]));
    model_last = tbl[9];
    total++; if (count !== 4'(exp_q.size()) || full !== 1'b1) begin bad++; $display("FAIL push_pop_full: count=%0d full=%0b want %0d/1", count, full, exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== e) begin bad++; $display("FAIL full_pop: valid=%0b data=%h want %h", rd_valid, rd_data, e); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_sticky: got %0b want 1", overflow); end
  endtask

`ifdef SEG7_HOLD_REPEAT_EN
  task automatic test_hold_repeat();
    logic [4:0] e;
    drive_pat(7'h00, 4);
    drive_pat(7'h77, 44);
    total++; if (count !== 4'd3) begin bad++; $display("FAIL hold_count: got %0d want 3", count); end
    drive_pat(7'h00, 40);
    total++; if (count !== 4'd3) begin bad++; $display("FAIL hold_cancel: got %0d want 3", count); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (rd_valid !== 1'b1 || rd_data !== e) begin bad++; $display("FAIL hold_pop: valid=%0b data=%h want %h", rd_valid, rd_data, e); end
      rd_en = 1'b1; step(); rd_en = 1'b0;
    end
  endtask
`endif

  initial begin
    @(negedge clk);
    test_reset();
    test_digit_stream();
    test_glitch();
    test_repeat_blank();
`ifdef SEG7_HOLD_REPEAT_EN
    test_hold_repeat();
`endif
    test_full_overflow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
